// File: rtl/pixel_pkg.sv
// Shared types for the pixel_reader scan-out path.
// Defining PIXEL_READER_COORD_EN adds x/y coordinates to every FIFO entry.
package pixel_pkg;

  typedef enum logic [1:0] {
    PR_IDLE  = 2'd0,
    PR_FETCH = 2'd1,
    PR_DRAIN = 2'd2
  } pr_state_e;

  typedef logic [7:0] pixel_t;

  // Coordinates travel at a fixed width and are trimmed at the output ports.
  localparam int COORD_W = 16;

  typedef struct packed {
    pixel_t pixel;
    logic   last;
`ifdef PIXEL_READER_COORD_EN
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
`endif
  } fifo_entry_t;

  function automatic int coord_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; simultaneous push and pop on a full
// FIFO is accepted and leaves the count unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pixel_reader.sv
// Scans a rectangular image out of data memory over the pixel port and streams
// it downstream; optional macro PIXEL_READER_COORD_EN adds out_x/out_y.
module pixel_reader
  import pixel_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR  = '0,
  parameter int               IMG_W      = 320,
  parameter int               IMG_H      = 320,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] pixel_address,
  input  logic [7:0]       pixel,
  output logic [7:0]       out_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
`ifdef PIXEL_READER_COORD_EN
  output logic [coord_bits(IMG_W)-1:0] out_x,
  output logic [coord_bits(IMG_H)-1:0] out_y,
`endif
  output logic             busy,
  output logic             done
);

  localparam int N_PIX = IMG_W * IMG_H;
  localparam int IDX_W = $clog2(N_PIX + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

  pr_state_e        state;
  logic [IDX_W-1:0] idx_p0;
  logic             is_last_p0;
  logic             credit;
  logic             issue;
  logic             accept;
  logic             vld_p1;
  logic             last_p1;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fifo_entry_t      push_entry;
  fifo_entry_t      head_entry;

`ifdef PIXEL_READER_COORD_EN
  localparam int XW = coord_bits(IMG_W);
  localparam int YW = coord_bits(IMG_H);
  logic [XW-1:0] x_p0;
  logic [YW-1:0] y_p0;
  logic [XW-1:0] x_p1;
  logic [YW-1:0] y_p1;
`endif

  // The read in flight counts against the FIFO so its return always has a slot.
  assign is_last_p0 = (idx_p0 == LAST_IDX);
  assign credit     = ~fifo_full && ((fifo_count + CW'(vld_p1)) < DEPTH_C);
  assign issue      = ((state == PR_IDLE) && start) || ((state == PR_FETCH) && credit);
  assign accept     = out_valid & out_ready;
  assign busy       = (state != PR_IDLE) | done;

  // Stage p0: address issue and scan control
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PR_IDLE;
      idx_p0        <= '0;
      vld_p1        <= 1'b0;
      pixel_address <= BASE_ADDR;
      done          <= 1'b0;
`ifdef PIXEL_READER_COORD_EN
      x_p0          <= '0;
      y_p0          <= '0;
`endif
    end else begin
      done   <= 1'b0;
      vld_p1 <= issue;
      if (issue) begin
        pixel_address <= BASE_ADDR + WIDTH'(idx_p0);
        idx_p0        <= idx_p0 + 1'b1;
`ifdef PIXEL_READER_COORD_EN
        if (x_p0 == XW'(IMG_W - 1)) begin
          x_p0 <= '0;
          y_p0 <= y_p0 + 1'b1;
        end else begin
          x_p0 <= x_p0 + 1'b1;
        end
`endif
      end
      case (state)
        PR_IDLE: begin
          if (start) state <= is_last_p0 ? PR_DRAIN : PR_FETCH;
        end
        PR_FETCH: begin
          if (issue && is_last_p0) state <= PR_DRAIN;
        end
        PR_DRAIN: begin
          if (accept && out_last) begin
            state  <= PR_IDLE;
            done   <= 1'b1;
            idx_p0 <= '0;
`ifdef PIXEL_READER_COORD_EN
            x_p0   <= '0;
            y_p0   <= '0;
`endif
          end
        end
        default: state <= PR_IDLE;
      endcase
    end
  end

  // Stage p1: tag the read in flight; its byte arrives on the pixel port
  always_ff @(posedge clk) begin
    if (issue) begin
      last_p1 <= is_last_p0;
`ifdef PIXEL_READER_COORD_EN
      x_p1    <= x_p0;
      y_p1    <= y_p0;
`endif
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pixel = pixel;
    push_entry.last  = last_p1;
`ifdef PIXEL_READER_COORD_EN
    push_entry.x     = COORD_W'(x_p1);
    push_entry.y     = COORD_W'(y_p1);
`endif
  end

  sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (vld_p1),
    .wdata(push_entry),
    .pop  (accept),
    .rdata(head_entry),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Stage p2: FIFO head; outputs forced to zero while nothing is buffered
  assign out_valid = ~fifo_empty;
  assign out_pixel = fifo_empty ? '0 : head_entry.pixel;
  assign out_last  = ~fifo_empty & head_entry.last;
`ifdef PIXEL_READER_COORD_EN
  assign out_x     = fifo_empty ? '0 : head_entry.x[XW-1:0];
  assign out_y     = fifo_empty ? '0 : head_entry.y[YW-1:0];
`endif

endmodule

// File: tb/tb_pixel_reader.sv
// Directed bench for pixel_reader: 4x2 image with scoreboard, plus a second
// instance exercising address wrap at the top of the address space.
module tb_pixel_reader;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int DEPTH = 4;
  localparam int N     = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] pixel_address;
  logic [7:0]  pixel;
  logic [7:0]  out_pixel;
  logic        out_valid, out_last, busy, done;

  logic        start2 = 1'b0;
  logic [31:0] addr2;
  logic [7:0]  pixel2;
  logic [7:0]  out_pixel2;
  logic        out_valid2, out_last2, busy2, done2;

`ifdef PIXEL_READER_COORD_EN
  logic [1:0] out_x, out_x2;
  logic [0:0] out_y, out_y2;
`endif

  logic [7:0] mem_seed = 8'h00;
  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int acc = 0;

  always #5 clk = ~clk;

  assign pixel  = mem_seed + pixel_address[7:0];
  assign pixel2 = addr2[7:0] ^ 8'h5A;

  pixel_reader #(
    .WIDTH(32), .BASE_ADDR(32'h0), .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pixel_address(pixel_address),
    .pixel(pixel), .out_pixel(out_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
`ifdef PIXEL_READER_COORD_EN
    .out_x(out_x), .out_y(out_y),
`endif
    .busy(busy), .done(done)
  );

  pixel_reader #(
    .WIDTH(32), .BASE_ADDR(32'hFFFF_FFFE), .IMG_W(4), .IMG_H(1), .FIFO_DEPTH(DEPTH)
  ) dut_wrap (
    .clk(clk), .reset(reset), .start(start2), .pixel_address(addr2),
    .pixel(pixel2), .out_pixel(out_pixel2), .out_valid(out_valid2),
    .out_ready(1'b1), .out_last(out_last2),
`ifdef PIXEL_READER_COORD_EN
    .out_x(out_x2), .out_y(out_y2),
`endif
    .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] seed);
    for (int k = 0; k < N; k++) exp_q.push_back({(k == N - 1), seed + 8'(k)});
  endtask

  // Scoreboard pop for the handshake about to complete at the next edge.
  task automatic observe();
    logic [8:0] e;
    if (!reset && out_valid && out_ready) begin
      acc++;
      if (exp_q.size() == 0) begin
        chk("sb_extra_pixel", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pixel", 32'(out_pixel), 32'(e[7:0]));
        chk("sb_last", 32'(out_last), 32'(e[8]));
      end
    end
  endtask

  task automatic clk_cycle();
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input int hold_until, input int budget, output int cyc);
    cyc = 0;
    start = 1'b1;
    do begin
      clk_cycle();
      cyc++;
      start = (cyc < hold_until);
      if (cyc == 1) chk("latency_valid_c1", 32'(out_valid), 32'd0);
      if (cyc == 2) chk("latency_valid_c2", 32'(out_valid), 32'd1);
    end while (!done && cyc < budget);
    chk("scan_done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int cyc;
    int base;
    int done_at;
    logic [31:0] wexp [4];
    wexp[0] = 32'hFFFF_FFFE;
    wexp[1] = 32'hFFFF_FFFF;
    wexp[2] = 32'h0000_0000;
    wexp[3] = 32'h0000_0001;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", pixel_address, 32'h0);
    chk("rst_out_pixel", 32'(out_pixel), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr_wrap", addr2, 32'hFFFF_FFFE);
    reset = 1'b0;

    // Idle without start
    for (int c = 0; c < 20; c++) begin
      clk_cycle();
      chk("idle_addr", pixel_address, 32'h0);
      chk("idle_valid", 32'(out_valid), 32'd0);
    end

    // Basic stream, out_ready held high
    mem_seed = 8'h10;
    out_ready = 1'b1;
    load(8'h10);
    base = acc;
    scan(1, 40, cyc);
    chk("basic_cycles", 32'(cyc), 32'd10);
    chk("basic_busy_at_done", 32'(busy), 32'd1);
    chk("basic_count", 32'(acc - base), 32'd8);
    chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);
    clk_cycle();
    chk("basic_done_pulse", 32'(done), 32'd0);
    chk("basic_busy_after", 32'(busy), 32'd0);

    // Backpressure: ten stalled cycles, then release
    mem_seed = 8'h40;
    out_ready = 1'b0;
    load(8'h40);
    base = acc;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      clk_cycle();
      start = 1'b0;
      if (c >= 2) begin
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_pixel_stable", 32'(out_pixel), 32'h40);
      end
    end
    chk("bp_issued_addr", pixel_address, 32'(DEPTH - 1));
    chk("bp_none_accepted", 32'(acc - base), 32'd0);
    out_ready = 1'b1;
    cyc = 0;
    do begin
      clk_cycle();
      cyc++;
    end while (!done && cyc < 50);
    chk("bp_done_seen", 32'(done), 32'd1);
    chk("bp_count", 32'(acc - base), 32'd8);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    clk_cycle();

    // start held through FETCH and DRAIN is ignored
    mem_seed = 8'h60;
    load(8'h60);
    base = acc;
    scan(9, 40, cyc);
    chk("restart_cycles", 32'(cyc), 32'd10);
    for (int c = 0; c < 5; c++) begin
      clk_cycle();
      chk("restart_no_done", 32'(done), 32'd0);
      chk("restart_no_valid", 32'(out_valid), 32'd0);
    end
    chk("restart_count", 32'(acc - base), 32'd8);
    chk("restart_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-FETCH after three pixels, then a fresh scan
    mem_seed = 8'h80;
    load(8'h80);
    base = acc;
    start = 1'b1;
    cyc = 0;
    do begin
      clk_cycle();
      start = 1'b0;
      cyc++;
    end while ((acc - base) < 3 && cyc < 20);
    chk("midrst_three_accepted", 32'(acc - base), 32'd3);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    clk_cycle();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", pixel_address, 32'h0);
    reset = 1'b0;
    exp_q.delete();
    clk_cycle();
    chk("midrst_no_stale", 32'(out_valid), 32'd0);
    mem_seed = 8'h90;
    load(8'h90);
    base = acc;
    scan(1, 40, cyc);
    chk("midrst_fresh_cycles", 32'(cyc), 32'd10);
    chk("midrst_fresh_count", 32'(acc - base), 32'd8);
    chk("midrst_fresh_sb_empty", 32'(exp_q.size()), 32'd0);
    clk_cycle();

    // Address wrap at top of address space
    start2 = 1'b1;
    done_at = 0;
    for (int c = 1; c <= 8; c++) begin
      clk_cycle();
      start2 = 1'b0;
      if (c <= 4) chk("wrap_addr", addr2, wexp[c-1]);
      if (c >= 2 && c <= 5) begin
        chk("wrap_valid", 32'(out_valid2), 32'd1);
        chk("wrap_pixel", 32'(out_pixel2), 32'(wexp[c-2][7:0] ^ 8'h5A));
        chk("wrap_last", 32'(out_last2), 32'(c == 5));
      end
      if (done2 && done_at == 0) begin
        done_at = c;
        chk("wrap_busy_at_done", 32'(busy2), 32'd1);
      end
    end
    chk("wrap_done_cycle", 32'(done_at), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
